pipe_flush_ctrl: RTL and testbench
==================================

PIPE_FLUSH_CTRL -- requirements
Module: pipe_flush_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles the IF/ID stages are flushed after a redirect (legal 1..7).
REQ-002 Parameter RESET_ADDR, default `ZERO, value driven on redirect_address_out after reset.
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n_in  input  1  asynchronous, active-low reset.
REQ-005 jump_enable_in  input  1  taken-jump/branch request from execute stage, combinational, level.
REQ-006 jump_address_in  input  `ADDR_WIDTH  target accompanying jump_enable_in.
REQ-007 bus_hold_in  input  1  bus arbiter busy; pipeline must not advance.
REQ-008 exe_hold_in  input  1  multi-cycle execute unit busy.
REQ-009 redirect_valid_out  output  1  one-cycle pulse; pc register loads redirect_address_out, overriding hold_pc_out.
REQ-010 redirect_address_out  output  `ADDR_WIDTH  registered, word-aligned redirect target.
REQ-011 hold_pc_out, hold_if_out, hold_id_out  output  1 each  stage stall enables.
REQ-012 flush_if_out, flush_id_out  output  1 each  replace stage contents with NOP bubble.
REQ-013 misaligned_out  output  1  one-cycle pulse: accepted target had bits[1:0] != 0.
REQ-014 jump_count_out  output  32  saturating count of redirects issued.

Function
REQ-015 FSM states IDLE, PEND, FLUSH; encoding 2 bits.
REQ-016 IDLE, jump_enable_in=1, bus_hold_in=0: next cycle redirect_valid_out=1, redirect_address_out={jump_address_in[ADDR_WIDTH-1:2],2'b00}, state->FLUSH, flush counter=FLUSH_CYCLES-1.
REQ-017 IDLE, jump_enable_in=1, bus_hold_in=1: latch target into pending register, state->PEND, no redirect.
REQ-018 PEND: hold_pc/if/id asserted; jump_enable_in ignored; first cycle with bus_hold_in=0 behaves as REQ-016 using pending target.
REQ-019 FLUSH: flush_if_out=flush_id_out=1 every cycle; jump_enable_in ignored (wrong-path); counter decrements when bus_hold_in=0, freezes when 1; counter=0 with bus_hold_in=0 -> IDLE.
REQ-020 FLUSH_CYCLES=1: exactly one flush cycle, then IDLE.
REQ-021 hold_pc_out=hold_if_out=hold_id_out = bus_hold_in | (state==PEND) | (exe_hold_in & state!=FLUSH), combinational.
REQ-022 Priority: bus_hold_in > jump_enable_in > exe_hold_in.
REQ-023 redirect_valid_out never asserted in two consecutive cycles.
REQ-024 misaligned_out pulses in same cycle as redirect_valid_out when target bits[1:0]!=0.
REQ-025 jump_count_out increments by 1 per redirect_valid_out; holds at 32'hFFFF_FFFF.
REQ-026 redirect_address_out holds last value between pulses.

Reset
REQ-027 reset_n_in=0 immediately: state=IDLE, counters=0, redirect_valid_out=0, redirect_address_out=RESET_ADDR, misaligned_out=0, jump_count_out=0, flush outputs 0.
REQ-028 Reset during PEND or FLUSH discards pending target and remaining flush cycles; no redirect follows deassertion.
REQ-029 Hold outputs follow REQ-021 during reset with state=IDLE.

Structure
REQ-030 State encoding and FLUSH_CYCLES default in shared defines.v alongside `ADDR_WIDTH/`ZERO.
REQ-031 Saturating counter as sub-module sat_counter (WIDTH parameter, inc, value); rest flat.

Verification
REQ-032 IDLE, jump 0x0000_0100, no holds -> next cycle redirect 0x100 pulse, flush 2 cycles, IDLE, jump_count_out=1.
REQ-033 jump 0x200 with bus_hold_in=1 for 3 cycles -> PEND 3 cycles with holds, redirect 0x200 cycle after release, then 2 flush cycles.
REQ-034 jump 0x103 -> redirect 0x100, misaligned_out pulse same cycle.
REQ-035 bus_hold_in high 2 cycles mid-FLUSH -> flush lasts 4 cycles total, single redirect.
REQ-036 reset_n_in low in PEND (target 0x300) -> outputs reset immediately, no redirect after release.
REQ-037 exe_hold_in=1 during FLUSH -> no holds asserted; in IDLE -> holds asserted same cycle.

Source files
------------

// File: rtl/pipe_flush_ctrl_pkg.sv
// Shared types, widths and helpers for the pipeline flush/redirect controller.
package pipe_flush_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] ZERO = {ADDR_WIDTH{1'b0}};
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/pipe_flush_ctrl_if.sv
// Execute-stage / pipeline-control bundle; slave is the flush controller itself.
interface pipe_flush_ctrl_if;
  import pipe_flush_ctrl_pkg::*;

  logic                  jump_enable_in;
  logic [ADDR_WIDTH-1:0] jump_address_in;
  logic                  bus_hold_in;
  logic                  exe_hold_in;
  logic                  redirect_valid_out;
  logic [ADDR_WIDTH-1:0] redirect_address_out;
  logic                  hold_pc_out;
  logic                  hold_if_out;
  logic                  hold_id_out;
  logic                  flush_if_out;
  logic                  flush_id_out;
  logic                  misaligned_out;
  logic [31:0]           jump_count_out;

  modport master (
    output jump_enable_in, jump_address_in, bus_hold_in, exe_hold_in,
    input  redirect_valid_out, redirect_address_out, hold_pc_out, hold_if_out,
           hold_id_out, flush_if_out, flush_id_out, misaligned_out, jump_count_out
  );

  modport slave (
    input  jump_enable_in, jump_address_in, bus_hold_in, exe_hold_in,
    output redirect_valid_out, redirect_address_out, hold_pc_out, hold_if_out,
           hold_id_out, flush_if_out, flush_id_out, misaligned_out, jump_count_out
  );

endinterface

// File: rtl/pipe_flush_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;

  // count register, frozen once every bit is set
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_value <= {WIDTH{1'b0}};
    end else if (inc && (r_value != {WIDTH{1'b1}})) begin
      r_value <= r_value + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_value <= r_value;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/pipe_flush_ctrl.sv
// Branch/jump redirect controller: issues a one-cycle PC redirect, then flushes
// IF/ID for FLUSH_CYCLES cycles; a redirect blocked by the bus waits in PEND.
module pipe_flush_ctrl
  import pipe_flush_ctrl_pkg::*;
#(
  parameter int                    FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR   = ZERO
) (
  input  logic               clk_in,
  input  logic               reset_n_in,
  pipe_flush_ctrl_if.slave   bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [FLUSH_CNT_W-1:0]  r_flush_cnt;
  logic [FLUSH_CNT_W-1:0]  w_flush_cnt_next;
  logic [ADDR_WIDTH-1:0]   r_pend_addr;
  logic [ADDR_WIDTH-1:0]   w_pend_addr_next;
  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_target;
  logic                    r_redirect_valid;
  logic [ADDR_WIDTH-1:0]   r_redirect_addr;
  logic                    r_misaligned;
  logic                    w_hold;
  logic [31:0]             w_jump_count;

  // state, flush counter and pending-target registers
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= {FLUSH_CNT_W{1'b0}};
      r_pend_addr <= ZERO;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_pend_addr <= w_pend_addr_next;
    end
  end

  // next-state: bus hold outranks a jump, and jumps are wrong-path while PEND/FLUSH
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_pend_addr_next = r_pend_addr;
    w_accept         = 1'b0;
    w_target         = r_pend_addr;
    case (r_state)
      ST_IDLE: begin
        if (bus.jump_enable_in) begin
          if (bus.bus_hold_in) begin
            w_pend_addr_next = bus.jump_address_in;
            w_state_next     = ST_PEND;
          end else begin
            w_accept         = 1'b1;
            w_target         = bus.jump_address_in;
            w_state_next     = ST_FLUSH;
            w_flush_cnt_next = FLUSH_LOAD;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (!bus.bus_hold_in) begin
          w_accept         = 1'b1;
          w_target         = r_pend_addr;
          w_state_next     = ST_FLUSH;
          w_flush_cnt_next = FLUSH_LOAD;
        end else begin
          w_state_next = ST_PEND;
        end
      end
      ST_FLUSH: begin
        if (bus.bus_hold_in) begin
          w_flush_cnt_next = r_flush_cnt;
        end else if (r_flush_cnt == {FLUSH_CNT_W{1'b0}}) begin
          w_state_next = ST_IDLE;
        end else begin
          w_flush_cnt_next = r_flush_cnt - {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_next     = ST_IDLE;
        w_flush_cnt_next = {FLUSH_CNT_W{1'b0}};
      end
    endcase
  end

  // redirect pulse, aligned target and misalignment flag
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_redirect_valid <= 1'b0;
      r_redirect_addr  <= RESET_ADDR;
      r_misaligned     <= 1'b0;
    end else begin
      r_redirect_valid <= w_accept;
      r_misaligned     <= w_accept & is_misaligned(w_target);
      if (w_accept) begin
        r_redirect_addr <= word_align(w_target);
      end else begin
        r_redirect_addr <= r_redirect_addr;
      end
    end
  end

  sat_counter #(.WIDTH(32)) u_jump_cnt (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .inc        (w_accept),
    .value      (w_jump_count)
  );

  // a flushing stage holds NOPs, so a busy execute unit need not stall it
  assign w_hold = bus.bus_hold_in | (r_state == ST_PEND) |
                  (bus.exe_hold_in & (r_state != ST_FLUSH));

  assign bus.redirect_valid_out   = r_redirect_valid;
  assign bus.redirect_address_out = r_redirect_addr;
  assign bus.misaligned_out       = r_misaligned;
  assign bus.jump_count_out       = w_jump_count;
  assign bus.hold_pc_out          = w_hold;
  assign bus.hold_if_out          = w_hold;
  assign bus.hold_id_out          = w_hold;
  assign bus.flush_if_out         = (r_state == ST_FLUSH);
  assign bus.flush_id_out         = (r_state == ST_FLUSH);

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Directed bench for pipe_flush_ctrl: a scoreboard of expected redirects plus a
// second instance with FLUSH_CYCLES=1 sharing the same stimulus.
module tb_pipe_flush_ctrl;
  import pipe_flush_ctrl_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        mis;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        bus_hold;
  logic        exe_hold;

  int   checks = 0;
  int   errors = 0;
  int   f1_cycles = 0;
  logic prev_valid = 1'b0;
  exp_t q[$];

  pipe_flush_ctrl_if if0 ();
  pipe_flush_ctrl_if if1 ();

  assign if0.jump_enable_in  = jump_en;
  assign if0.jump_address_in = jump_addr;
  assign if0.bus_hold_in     = bus_hold;
  assign if0.exe_hold_in     = exe_hold;
  assign if1.jump_enable_in  = jump_en;
  assign if1.jump_address_in = jump_addr;
  assign if1.bus_hold_in     = bus_hold;
  assign if1.exe_hold_in     = exe_hold;

  pipe_flush_ctrl dut (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .bus        (if0)
  );

  pipe_flush_ctrl #(.FLUSH_CYCLES(1)) dut1 (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .bus        (if1)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic push(input logic [31:0] addr, input logic mis);
    exp_t e;
    e.addr = addr;
    e.mis  = mis;
    q.push_back(e);
  endtask

  // counts consecutive flush cycles of the main instance, holding the bus for the first hold_cycles
  task automatic count_flush(input int hold_cycles, output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      bus_hold = (n < hold_cycles);
      #1;
      if (!if0.flush_if_out) break;
      n++;
      tick();
    end
    bus_hold = 1'b0;
  endtask

  // scoreboard side: every redirect pulse must match the oldest expected target
  always @(negedge clk_in) begin
    exp_t e;
    if (if1.flush_if_out) f1_cycles++;
    if (if0.redirect_valid_out) begin
      chk("no_back_to_back", {31'd0, prev_valid}, 32'd0);
      chk("sb_nonempty", {31'd0, (q.size() > 0)}, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_addr", if0.redirect_address_out, e.addr);
        chk("sb_mis", {31'd0, if0.misaligned_out}, {31'd0, e.mis});
      end
    end else begin
      chk("mis_idle", {31'd0, if0.misaligned_out}, 32'd0);
    end
    prev_valid = if0.redirect_valid_out;
  end

  initial begin
    int n;
    reset_n_in = 1'b0;
    jump_en    = 1'b0;
    jump_addr  = 32'h0000_0000;
    bus_hold   = 1'b0;
    exe_hold   = 1'b1;
    #1;
    chk("rst_valid", {31'd0, if0.redirect_valid_out}, 32'd0);
    chk("rst_addr", if0.redirect_address_out, 32'h0000_0000);
    chk("rst_flush_if", {31'd0, if0.flush_if_out}, 32'd0);
    chk("rst_flush_id", {31'd0, if0.flush_id_out}, 32'd0);
    chk("rst_count", if0.jump_count_out, 32'd0);
    chk("rst_hold_exe", {29'd0, if0.hold_pc_out, if0.hold_if_out, if0.hold_id_out}, 32'd7);
    exe_hold = 1'b0;
    tick();
    tick();
    reset_n_in = 1'b1;
    tick();

    // basic redirect, wrong-path jump during flush ignored
    jump_en = 1'b1; jump_addr = 32'h0000_0100; push(32'h0000_0100, 1'b0);
    tick();
    jump_addr = 32'h0000_0440;
    #1;
    chk("t1_flush_if", {31'd0, if0.flush_if_out}, 32'd1);
    chk("t1_flush_id", {31'd0, if0.flush_id_out}, 32'd1);
    chk("t1_no_hold", {31'd0, if0.hold_pc_out}, 32'd0);
    chk("t1_count_pulse", if0.jump_count_out, 32'd1);
    tick();
    jump_en = 1'b0;
    chk("t1_flush2", {31'd0, if0.flush_if_out}, 32'd1);
    chk("t1_single_pulse", {31'd0, if0.redirect_valid_out}, 32'd0);
    tick();
    chk("t1_idle", {31'd0, if0.flush_if_out}, 32'd0);
    chk("t1_count", if0.jump_count_out, 32'd1);
    chk("t1_f1_cycles", f1_cycles, 32'd1);

    // redirect deferred by bus hold for three cycles
    jump_en = 1'b1; jump_addr = 32'h0000_0200; bus_hold = 1'b1; push(32'h0000_0200, 1'b0);
    #1;
    chk("t2_hold_bus", {31'd0, if0.hold_pc_out}, 32'd1);
    tick();
    jump_addr = 32'h0000_0440;
    #1;
    chk("t2_p1_hold", {31'd0, if0.hold_if_out}, 32'd1);
    chk("t2_p1_valid", {31'd0, if0.redirect_valid_out}, 32'd0);
    tick();
    chk("t2_p2_hold", {31'd0, if0.hold_id_out}, 32'd1);
    tick();
    bus_hold = 1'b0; jump_en = 1'b0;
    #1;
    chk("t2_p3_hold", {31'd0, if0.hold_pc_out}, 32'd1);
    chk("t2_p3_valid", {31'd0, if0.redirect_valid_out}, 32'd0);
    tick();
    chk("t2_redirect", {31'd0, if0.redirect_valid_out}, 32'd1);
    count_flush(0, n);
    chk("t2_flush_len", n, 32'd2);

    // misaligned target gets aligned and flagged
    jump_en = 1'b1; jump_addr = 32'h0000_0103; push(32'h0000_0100, 1'b1);
    tick();
    jump_en = 1'b0;
    #1;
    chk("t3_mis", {31'd0, if0.misaligned_out}, 32'd1);
    chk("t3_addr", if0.redirect_address_out, 32'h0000_0100);
    count_flush(0, n);
    chk("t3_flush_len", n, 32'd2);
    chk("t3_addr_held", if0.redirect_address_out, 32'h0000_0100);

    // bus hold freezes the flush counter
    jump_en = 1'b1; jump_addr = 32'h0000_0480; push(32'h0000_0480, 1'b0);
    tick();
    jump_en = 1'b0;
    count_flush(2, n);
    chk("t4_flush_len", n, 32'd4);
    chk("t4_count", if0.jump_count_out, 32'd4);

    // reset while a target is pending
    jump_en = 1'b1; jump_addr = 32'h0000_0300; bus_hold = 1'b1;
    tick();
    jump_en = 1'b0;
    #1;
    chk("t5_pend_hold", {31'd0, if0.hold_pc_out}, 32'd1);
    tick();
    reset_n_in = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, if0.redirect_valid_out}, 32'd0);
    chk("t5_rst_addr", if0.redirect_address_out, 32'h0000_0000);
    chk("t5_rst_count", if0.jump_count_out, 32'd0);
    chk("t5_rst_hold_bus", {31'd0, if0.hold_pc_out}, 32'd1);
    bus_hold = 1'b0;
    #1;
    chk("t5_rst_hold_idle", {31'd0, if0.hold_pc_out}, 32'd0);
    tick();
    tick();
    reset_n_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_quiet_valid", {31'd0, if0.redirect_valid_out}, 32'd0);
      chk("t5_quiet_flush", {31'd0, if0.flush_if_out}, 32'd0);
    end

    // execute-unit hold: active in IDLE, masked during FLUSH
    exe_hold = 1'b1;
    #1;
    chk("t6_idle_hold", {31'd0, if0.hold_pc_out}, 32'd1);
    jump_en = 1'b1; jump_addr = 32'h0000_0500; push(32'h0000_0500, 1'b0);
    tick();
    jump_en = 1'b0;
    #1;
    chk("t6_flush_hold", {29'd0, if0.hold_pc_out, if0.hold_if_out, if0.hold_id_out}, 32'd0);
    count_flush(0, n);
    chk("t6_flush_len", n, 32'd2);
    chk("t6_idle_hold_again", {31'd0, if0.hold_pc_out}, 32'd1);
    exe_hold = 1'b0;

    tick();
    tick();
    chk("end_sb_empty", q.size(), 32'd0);
    chk("end_count", if0.jump_count_out, 32'd1);
    chk("end_count_f1", if1.jump_count_out, 32'd1);
    chk("end_f1_cycles", f1_cycles, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
